pio_cmd_sequencer: RTL and testbench



---
 rtl/pio_cmd_sequencer.sv | 135 +++++++++++++
 tb/tb_pio_cmd_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pio_cmd_sequencer.sv
// rtl/pio_cmd_sequencer.sv - HPS PIO start/done handshake, opcode decode and command issue
// Optional watchdog on ISSUE/WAIT enabled by defining CMD_WATCHDOG_EN.
module pio_cmd_sequencer #(
  parameter int INSTR_W     = 29,
  parameter int OPCODE_W    = 4,
  parameter int NUM_OPS     = 9,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              ctrl_in,
  input  logic [INSTR_W-1:0]      instr_in,
  output logic [3:0]              status_out,
  output logic                    cmd_valid,
  input  logic                    cmd_ready,
  output logic [OPCODE_W-1:0]     cmd_opcode,
  output logic [INSTR_W-OPCODE_W-1:0] cmd_payload,
  input  logic                    exec_done,
  input  logic                    exec_error
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DECODE   = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT     = 3'd3;
  localparam logic [2:0] S_COMPLETE = 3'd4;

  localparam logic [OPCODE_W:0] NUM_OPS_V = NUM_OPS[OPCODE_W:0];

  logic [2:0] state;
  logic       start_q;
  logic       done;
  logic       error;
  logic       start_edge;
  logic       busy;
  logic       illegal_op;
  logic       wdog_hit;

  assign start_edge = ctrl_in[0] & ~start_q;
  assign busy       = (state == S_DECODE) || (state == S_ISSUE) || (state == S_WAIT);
  assign illegal_op = {1'b0, cmd_opcode} >= NUM_OPS_V;
  assign status_out = {error, state == S_IDLE, done, busy};

`ifdef CMD_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // DECODE is the only way into ISSUE, so zeroing there restarts the count on entry
  always_ff @(posedge clk) begin
    if (reset || state == S_DECODE) begin
      wdog_cnt <= '0;
    end else if (state == S_ISSUE || state == S_WAIT) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  assign wdog_hit = (state == S_ISSUE || state == S_WAIT) && (wdog_cnt == WDOG_LAST);
`else
  assign wdog_hit = 1'b0;
`endif

  // start_q tracks even through reset/clear so a held start level never looks like a new edge
  always_ff @(posedge clk) begin
    start_q <= ctrl_in[0];
    if (reset) begin
      state       <= S_IDLE;
      cmd_valid   <= 1'b0;
      cmd_opcode  <= '0;
      cmd_payload <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else if (ctrl_in[1]) begin
      state     <= S_IDLE;
      cmd_valid <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            cmd_opcode  <= instr_in[OPCODE_W-1:0];
            cmd_payload <= instr_in[INSTR_W-1:OPCODE_W];
            done        <= 1'b0;
            error       <= 1'b0;
            state       <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (illegal_op) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= S_COMPLETE;
          end else if (cmd_opcode == '0) begin
            done  <= 1'b1;
            state <= S_COMPLETE;
          end else begin
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (wdog_hit) begin
            cmd_valid <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            state     <= S_COMPLETE;
          end else if (cmd_valid && cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wdog_hit) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= S_COMPLETE;
          end else if (exec_done) begin
            error <= exec_error;
            done  <= 1'b1;
            state <= S_COMPLETE;
          end
        end
        S_COMPLETE: begin
          if (!ctrl_in[0]) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
// tb/tb_pio_cmd_sequencer.sv - scoreboard bench for pio_cmd_sequencer
module tb_pio_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ctrl_in;
  logic [28:0] instr_in;
  logic [3:0]  status_out;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_opcode;
  logic [24:0] cmd_payload;
  logic        exec_done;
  logic        exec_error;

  int checks = 0;
  int errors = 0;

  logic [28:0] cmd_q[$];
  logic [3:0]  stat_q[$];
  logic        prev_done = 1'b0;

  pio_cmd_sequencer #(
    .INSTR_W(29), .OPCODE_W(4), .NUM_OPS(9), .WDOG_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .instr_in(instr_in),
    .status_out(status_out), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_payload(cmd_payload),
    .exec_done(exec_done), .exec_error(exec_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference rules: which opcodes reach the execution unit and what error they end with
  function automatic bit model_issues(input logic [3:0] op);
    return (op != 0) && (op < 9);
  endfunction

  function automatic logic model_error(input logic [3:0] op, input logic eerr);
    if (op >= 9) return 1'b1;
    if (op == 0) return 1'b0;
    return eerr;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid && cmd_ready) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd", {cmd_payload, cmd_opcode}, 32'hDEAD);
        end else begin
          check("cmd_accept", {3'b0, cmd_payload, cmd_opcode}, {3'b0, cmd_q.pop_front()});
        end
      end
      if (status_out[1] && !prev_done) begin
        if (stat_q.size() == 0) begin
          check("unexpected_done", status_out, 4'hF);
        end else begin
          check("done_status", status_out, stat_q.pop_front());
        end
      end
      prev_done <= status_out[1];
    end else begin
      prev_done <= 1'b0;
    end
  end

  task automatic run_cmd(input logic [28:0] instr, input int rdly, input int ddly, input logic eerr);
    logic [3:0] op;
    bit         issue;
    logic       exp_err;
    op      = instr[3:0];
    issue   = model_issues(op);
    exp_err = model_error(op, eerr);
    if (issue) cmd_q.push_back(instr);
    stat_q.push_back({exp_err, 3'b010});
    instr_in  = instr;
    cmd_ready = 1'b0;
    ctrl_in   = 2'b01;
    tick;
    check("decode_busy", status_out, 4'b0001);
    tick;
    if (issue) begin
      check("valid_latency", cmd_valid, 1'b1);
      for (int i = 0; i < rdly; i++) begin
        instr_in = 29'($urandom);
        tick;
        check("hold_valid", cmd_valid, 1'b1);
        check("hold_cmd", {3'b0, cmd_payload, cmd_opcode}, {3'b0, instr});
      end
      cmd_ready = 1'b1;
      tick;
      cmd_ready = 1'b0;
      check("valid_drop", cmd_valid, 1'b0);
      check("wait_busy", status_out, 4'b0001);
      for (int i = 0; i < ddly; i++) tick;
      exec_done  = 1'b1;
      exec_error = eerr;
      tick;
      exec_done  = 1'b0;
      exec_error = 1'b0;
    end
    check("complete_status", status_out, {exp_err, 3'b010});
    ctrl_in = 2'b00;
    tick;
    check("idle_after", status_out, {exp_err, 3'b110});
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ctrl_in = 2'b00; instr_in = '0;
    cmd_ready = 1'b0; exec_done = 1'b0; exec_error = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    repeat (5) tick;
    check("reset_status", status_out, 4'b0100);
    check("reset_valid", cmd_valid, 1'b0);
    check("reset_opcode", cmd_opcode, 4'h0);

    run_cmd(29'h00012343, 0, 9, 1'b0);
    check("first_payload", cmd_payload, 25'h0001234);
    run_cmd(29'h0000123F, 0, 0, 1'b0);
    run_cmd(29'h00000000, 0, 0, 1'b0);
    run_cmd(29'h0055AA07, 20, 3, 1'b1);

    // clear and exec_done in the same cycle: clear wins, no done, held start does not retrigger
    instr_in = 29'h0ABCDE5;
    cmd_q.push_back(29'h0ABCDE5);
    ctrl_in = 2'b01;
    tick; tick;
    cmd_ready = 1'b1;
    tick;
    cmd_ready = 1'b0;
    tick;
    ctrl_in = 2'b11; exec_done = 1'b1; exec_error = 1'b1;
    tick;
    exec_done = 1'b0; exec_error = 1'b0;
    check("clear_status", status_out, 4'b0100);
    check("clear_valid", cmd_valid, 1'b0);
    ctrl_in = 2'b01;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("no_retrigger", status_out, 4'b0100);
    end
    ctrl_in = 2'b00;
    tick;

    // reset while a command is being offered
    instr_in = 29'h1234564;
    ctrl_in = 2'b01;
    tick; tick;
    reset = 1'b1;
    tick;
    check("rst_mid_valid", cmd_valid, 1'b0);
    check("rst_mid_opcode", cmd_opcode, 4'h0);
    check("rst_mid_status", status_out, 4'b0100);
    reset = 1'b0; ctrl_in = 2'b00;
    tick;

    for (int n = 0; n < 30; n++) begin
      run_cmd(29'($urandom), $urandom_range(0, 3), $urandom_range(0, 5), 1'($urandom));
    end

`ifdef CMD_WATCHDOG_EN
    instr_in = 29'h0000AB2;
    cmd_q.push_back(29'h0000AB2);
    stat_q.push_back(4'b1010);
    cmd_ready = 1'b1;
    ctrl_in = 2'b01;
    tick; tick;
    cmd_ready = 1'b0;
    for (int i = 0; i < 49; i++) begin
      tick;
      check("wdog_early", status_out[1], 1'b0);
    end
    tick;
    check("wdog_fire", status_out, 4'b1010);
    exec_done = 1'b1;
    tick;
    exec_done = 1'b0;
    check("wdog_stray_done", status_out, 4'b1010);
    ctrl_in = 2'b00;
    tick;
    check("wdog_idle", status_out, 4'b1110);
    tick;
`endif

    repeat (3) tick;
    check("cmd_q_drained", cmd_q.size(), 0);
    check("stat_q_drained", stat_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
